ram_bus_arbiter: RTL and testbench
==================================

// Module: ram_bus_arbiter
// PURPOSE
//  Two-master arbiter feeding the single generic-bus RAM port (ram_wrapper/ram_sim_model).
//  Merges instruction-fetch (I) and data (D) generic_bus requests, serialises them, and routes each response back.
//  Also provides a per-transaction slave timeout for simulation robustness.
// PARAMETERS
//  ADDR_W       32  address width (byte address, passed through unmodified)
//  DATA_W       32  data width; byte_en width is DATA_W/8
//  ROUND_ROBIN  1   1: alternate on contention; 0: fixed D-over-I priority
//  TIMEOUT_CYC  64  slave-busy cycles before forced completion; 0 disables (counter width $clog2(TIMEOUT_CYC+1))
// PORTS
//  CLK          in   1         clock, all state on rising edge
//  RST          in   1         synchronous, active-high reset
//  i_addr       in   ADDR_W    I master address
//  i_ren        in   1         I master read request (I never writes)
//  i_rdata      out  DATA_W    I read data, valid when i_busy==0
//  i_busy       out  1         I master stall; 0 = transaction complete this cycle
//  d_addr       in   ADDR_W    D master address
//  d_wdata      in   DATA_W    D write data
//  d_byte_en    in   DATA_W/8  D byte enables
//  d_ren/d_wen  in   1 each    D read/write request (never both)
//  d_rdata      out  DATA_W    D read data, valid when d_busy==0
//  d_busy       out  1         D master stall
//  s_addr       out  ADDR_W    slave address
//  s_wdata      out  DATA_W    slave write data
//  s_byte_en    out  DATA_W/8  slave byte enables (4'hF for I reads)
//  s_ren/s_wen  out  1 each    slave request
//  s_rdata      in   DATA_W    slave read data
//  s_busy       in   1         slave stall
//  timeout_err  out  1         one-cycle pulse on forced completion
// BEHAVIOUR
//  - Reset (RST=1 at edge): state=IDLE, last_grant=I, timer=0; outputs: s_ren=s_wen=0, s_addr/s_wdata/s_byte_en=0,
//    i_busy=d_busy=1, i_rdata=d_rdata=0, timeout_err=0. Reset mid-transaction abandons it; no completion reported.
//  - FSM: IDLE, SERVE_I, SERVE_D. Grant is registered; slave signals are driven only in SERVE_x.
//  - IDLE: no request -> stay. Only one requester -> SERVE_<it>. Both: ROUND_ROBIN=1 picks master != last_grant;
//    ROUND_ROBIN=0 picks D. last_grant updated on entry to SERVE_x.
//  - SERVE_x: slave outputs combinationally mirror master x; other master sees busy=1.
//    Completion = s_busy==0 while request held: x_busy=0, x_rdata=s_rdata (same cycle), next state IDLE.
//  - Latency: with zero-latency slave, request in cycle N -> completion (busy=0) in cycle N+1. Each further slave busy cycle adds one.
//  - Back-to-back: every completion returns to IDLE, so max throughput is one transaction per 2 cycles; fairness follows from IDLE re-arbitration.
//  - Master drops request while in SERVE_x (protocol violation): slave requests deassert that cycle, return to IDLE, no completion, no error.
//  - Timeout (TIMEOUT_CYC>0): timer clears on SERVE_x entry, increments each SERVE cycle with s_busy=1.
//    When timer==TIMEOUT_CYC-1 and s_busy=1: force completion (x_busy=0, x_rdata=0), timeout_err=1 for that cycle, go IDLE.
//  - i_rdata/d_rdata hold 0 whenever their busy is 1 (no stale data).
//  - Width: addresses/data pass unchanged; no alignment check (slave word-addresses).
// TESTING
//  1. Reset: hold RST 2 cycles with requests active -> s_ren=s_wen=0, i_busy=d_busy=1, timeout_err=0.
//  2. Single I read 0x0000_0100, slave rdata=0xDEADBEEF, s_busy=0 -> s_ren=1 in cycle 1, i_busy=0 and i_rdata=0xDEADBEEF in cycle 1.
//  3. I and D request together, ROUND_ROBIN=1 from reset -> D served first, I second; repeat -> order D,I,D,I; ROUND_ROBIN=0 -> D always first.
//  4. D write 0x200, wdata=0x12345678, byte_en=4'b0011, slave busy 3 cycles -> s_wen held 4 cycles with stable fields; d_busy=0 in 4th.
//  5. TIMEOUT_CYC=4, slave busy forever -> completion after 4 SERVE cycles, rdata=0, timeout_err pulses once, FSM IDLE.
//  6. Assert RST during SERVE_D with s_busy=1 -> next cycle all slave requests 0, busy=1; after release, pending I served normally.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// Two-master (I-fetch / data) arbiter onto a single generic-bus RAM port.
// Grant is registered; slave signals mirror the granted master while serving.
module ram_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_ren,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_busy,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_en,
  input  logic                d_ren,
  input  logic                d_wen,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_byte_en,
  output logic                s_ren,
  output logic                s_wen,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_busy,
  output logic                timeout_err
);

  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TO_EN ? TW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_e;

  state_e        state_q, state_d;
  gnt_e          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;

  logic d_req;
  logic to_hit;
  logic pick_d;

  assign d_req  = d_ren | d_wen;
  assign to_hit = TO_EN && s_busy && (timer_q == TO_LAST);

  // On contention: fixed priority favours D, round-robin avoids repeating
  always_comb begin
    pick_d = 1'b0;
    if (d_req && !i_ren) begin
      pick_d = 1'b1;
    end else if (d_req && i_ren) begin
      pick_d = (ROUND_ROBIN == 0) || (last_q == GNT_I);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    timer_d     = timer_q;
    s_addr      = '0;
    s_wdata     = '0;
    s_byte_en   = '0;
    s_ren       = 1'b0;
    s_wen       = 1'b0;
    i_busy      = 1'b1;
    d_busy      = 1'b1;
    i_rdata     = '0;
    d_rdata     = '0;
    timeout_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pick_d) begin
          state_d = SERVE_D;
          last_d  = GNT_D;
        end else if (i_ren) begin
          state_d = SERVE_I;
          last_d  = GNT_I;
        end
      end
      SERVE_I: begin
        s_addr    = i_addr;
        s_byte_en = '1;
        s_ren     = i_ren;
        if (!i_ren) begin
          state_d = IDLE;
        end else if (!s_busy) begin
          i_busy  = 1'b0;
          i_rdata = s_rdata;
          state_d = IDLE;
        end else if (to_hit) begin
          i_busy      = 1'b0;
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SERVE_D: begin
        s_addr    = d_addr;
        s_wdata   = d_wdata;
        s_byte_en = d_byte_en;
        s_ren     = d_ren;
        s_wen     = d_wen;
        if (!d_req) begin
          state_d = IDLE;
        end else if (!s_busy) begin
          d_busy  = 1'b0;
          d_rdata = s_rdata;
          state_d = IDLE;
        end else if (to_hit) begin
          d_busy      = 1'b0;
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= GNT_I;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Vector-table bench for ram_bus_arbiter: round-robin and fixed-priority
// instances share stimulus; expected outputs flow through a queue.
module tb_ram_bus_arbiter;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        sb;
    logic [31:0] srd;
  } in_t;

  typedef struct {
    logic        sr;
    logic        sw;
    logic [31:0] sa;
    logic [31:0] swd;
    logic [3:0]  sbe;
    logic        ib;
    logic        db;
    logic [31:0] ird;
    logic [31:0] drd;
    logic        te;
    logic        fib;
    logic        fdb;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, d_addr, d_wdata, s_rdata;
  logic        i_ren, d_ren, d_wen, s_busy;
  logic [3:0]  d_byte_en;
  logic [31:0] i_rdata, d_rdata, s_addr, s_wdata;
  logic [3:0]  s_byte_en;
  logic        i_busy, d_busy, s_ren, s_wen, timeout_err;
  logic [31:0] fx_i_rdata, fx_d_rdata, fx_s_addr, fx_s_wdata;
  logic [3:0]  fx_s_byte_en;
  logic        fx_i_busy, fx_d_busy, fx_s_ren, fx_s_wen, fx_te;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];
  out_t exp_q[$];

  always #5 clk = ~clk;

  ram_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1), .TIMEOUT_CYC(4)
  ) u_dut (
    .CLK(clk), .RST(rst),
    .i_addr(i_addr), .i_ren(i_ren),
    .i_rdata(i_rdata), .i_busy(i_busy),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_ren(d_ren), .d_wen(d_wen),
    .d_rdata(d_rdata), .d_busy(d_busy),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_byte_en(s_byte_en), .s_ren(s_ren), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_busy(s_busy),
    .timeout_err(timeout_err)
  );

  ram_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0), .TIMEOUT_CYC(4)
  ) u_fix (
    .CLK(clk), .RST(rst),
    .i_addr(i_addr), .i_ren(i_ren),
    .i_rdata(fx_i_rdata), .i_busy(fx_i_busy),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_ren(d_ren), .d_wen(d_wen),
    .d_rdata(fx_d_rdata), .d_busy(fx_d_busy),
    .s_addr(fx_s_addr), .s_wdata(fx_s_wdata),
    .s_byte_en(fx_s_byte_en), .s_ren(fx_s_ren), .s_wen(fx_s_wen),
    .s_rdata(s_rdata), .s_busy(s_busy),
    .timeout_err(fx_te)
  );

  function automatic in_t mk_i(
    logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
    logic [31:0] da, logic [31:0] dwd, logic [3:0] dbe,
    logic sb, logic [31:0] srd);
    in_t v;
    v.rst = r;  v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da;  v.dwd = dwd; v.dbe = dbe; v.sb = sb; v.srd = srd;
    return v;
  endfunction

  function automatic out_t mk_o(
    logic sr, logic sw, logic [31:0] sa, logic [31:0] swd,
    logic [3:0] sbe, logic ib, logic db, logic [31:0] ird,
    logic [31:0] drd, logic te, logic fib, logic fdb);
    out_t v;
    v.sr = sr; v.sw = sw; v.sa = sa; v.swd = swd; v.sbe = sbe;
    v.ib = ib; v.db = db; v.ird = ird; v.drd = drd; v.te = te;
    v.fib = fib; v.fdb = fdb;
    return v;
  endfunction

  function automatic out_t o_idle();
    return mk_o(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
  endfunction

  function automatic in_t i_none();
    return mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int row);
    out_t e;
    @(negedge clk);
    rst       = v.i.rst;
    i_ren     = v.i.ir;
    i_addr    = v.i.ia;
    d_ren     = v.i.dr;
    d_wen     = v.i.dw;
    d_addr    = v.i.da;
    d_wdata   = v.i.dwd;
    d_byte_en = v.i.dbe;
    s_busy    = v.i.sb;
    s_rdata   = v.i.srd;
    exp_q.push_back(v.o);
    #4;
    e = exp_q.pop_front();
    chk("s_ren", row, 32'(s_ren), 32'(e.sr));
    chk("s_wen", row, 32'(s_wen), 32'(e.sw));
    chk("s_addr", row, s_addr, e.sa);
    chk("s_wdata", row, s_wdata, e.swd);
    chk("s_byte_en", row, 32'(s_byte_en), 32'(e.sbe));
    chk("i_busy", row, 32'(i_busy), 32'(e.ib));
    chk("d_busy", row, 32'(d_busy), 32'(e.db));
    chk("i_rdata", row, i_rdata, e.ird);
    chk("d_rdata", row, d_rdata, e.drd);
    chk("timeout_err", row, 32'(timeout_err), 32'(e.te));
    chk("fix_i_busy", row, 32'(fx_i_busy), 32'(e.fib));
    chk("fix_d_busy", row, 32'(fx_d_busy), 32'(e.fdb));
  endtask

  initial begin
    vec_t  v;
    in_t   ci;
    out_t  srv_d_rd, srv_i_rd, srv_w, srv_ibz;

    // reset held with requests active
    ci = mk_i(1, 1, 32'h100, 1, 0, 32'h204, 0, 4'hF, 0, 0);
    vecs.push_back('{ci, o_idle()});
    vecs.push_back('{ci, o_idle()});
    // single I read, zero-latency slave
    ci = mk_i(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    vecs.push_back('{ci, o_idle()});
    vecs.push_back('{ci, mk_o(1, 0, 32'h100, 0, 4'hF, 0, 1,
                              32'hDEADBEEF, 0, 0, 0, 1)});
    vecs.push_back('{i_none(), o_idle()});
    // contention: RR gives D,I,D,I; fixed gives D every time
    ci = mk_i(0, 1, 32'h104, 1, 0, 32'h204, 0, 4'hF, 0, 32'h11111111);
    srv_d_rd = mk_o(1, 0, 32'h204, 0, 4'hF, 1, 0, 0,
                    32'h11111111, 0, 1, 0);
    srv_i_rd = mk_o(1, 0, 32'h104, 0, 4'hF, 0, 1, 32'h11111111,
                    0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      vecs.push_back('{ci, o_idle()});
      vecs.push_back('{ci, srv_d_rd});
      vecs.push_back('{ci, o_idle()});
      vecs.push_back('{ci, srv_i_rd});
    end
    vecs.push_back('{i_none(), o_idle()});
    // D write with 3 slave busy cycles
    ci = mk_i(0, 0, 0, 0, 1, 32'h200, 32'h12345678, 4'b0011, 1, 0);
    srv_w = mk_o(0, 1, 32'h200, 32'h12345678, 4'b0011, 1, 1,
                 0, 0, 0, 1, 1);
    vecs.push_back('{ci, o_idle()});
    for (int k = 0; k < 3; k++) vecs.push_back('{ci, srv_w});
    ci.sb  = 0;
    ci.srd = 32'hCAFEF00D;
    vecs.push_back('{ci, mk_o(0, 1, 32'h200, 32'h12345678, 4'b0011,
                              1, 0, 0, 32'hCAFEF00D, 0, 1, 0)});
    vecs.push_back('{i_none(), o_idle()});
    // timeout on I read with slave stuck busy
    ci = mk_i(0, 1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h55555555);
    srv_ibz = mk_o(1, 0, 32'h300, 0, 4'hF, 1, 1, 0, 0, 0, 1, 1);
    vecs.push_back('{ci, o_idle()});
    for (int k = 0; k < 3; k++) vecs.push_back('{ci, srv_ibz});
    vecs.push_back('{ci, mk_o(1, 0, 32'h300, 0, 4'hF, 0, 1,
                              0, 0, 1, 0, 1)});
    ci.ir = 0;
    vecs.push_back('{ci, o_idle()});
    // D drops its request mid-service
    ci = mk_i(0, 0, 0, 1, 0, 32'h400, 0, 4'hF, 1, 0);
    vecs.push_back('{ci, o_idle()});
    ci.dr = 0;
    vecs.push_back('{ci, mk_o(0, 0, 32'h400, 0, 4'hF, 1, 1,
                              0, 0, 0, 1, 1)});
    vecs.push_back('{i_none(), o_idle()});
    // reset during busy SERVE_D, then pending I served
    ci = mk_i(0, 0, 0, 1, 0, 32'h500, 0, 4'hF, 1, 0);
    vecs.push_back('{ci, o_idle()});
    ci = mk_i(1, 1, 32'h600, 1, 0, 32'h500, 0, 4'hF, 1, 0);
    vecs.push_back('{ci, mk_o(1, 0, 32'h500, 0, 4'hF, 1, 1,
                              0, 0, 0, 1, 1)});
    ci = mk_i(0, 1, 32'h600, 0, 0, 0, 0, 0, 1, 0);
    vecs.push_back('{ci, o_idle()});
    ci.sb  = 0;
    ci.srd = 32'h600DF00D;
    vecs.push_back('{ci, mk_o(1, 0, 32'h600, 0, 4'hF, 0, 1,
                              32'h600DF00D, 0, 0, 0, 1)});
    vecs.push_back('{i_none(), o_idle()});

    rst = 1'b1;
    i_ren = 0; i_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0;
    d_wdata = 0; d_byte_en = 0; s_busy = 0; s_rdata = 0;
    @(posedge clk);

    foreach (vecs[k]) apply(vecs[k], k);

    // held I request: one completion every second cycle
    for (int k = 0; k < 6; k++) begin
      v.i = mk_i(0, 1, 32'h700, 0, 0, 0, 0, 0, 0, 32'h0BADCAFE);
      if (k % 2 == 0) v.o = o_idle();
      else v.o = mk_o(1, 0, 32'h700, 0, 4'hF, 0, 1,
                      32'h0BADCAFE, 0, 0, 0, 1);
      apply(v, 100 + k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
